// File: rtl/seq_det_pkg.sv
// Shared constants, state type and helpers for the serial pattern detector.
package seq_det_pkg;

  localparam int unsigned DefPatLen  = 6;
  localparam int unsigned DefCntW    = 8;
  localparam logic [5:0]  DefPattern = 6'b101001;

  typedef enum logic [0:0] {
    StFilling,
    StArmed
  } det_state_e;

  // Width needed to hold a fill count of 0..pat_len inclusive.
  function automatic int unsigned fill_width(input int unsigned pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky saturation flag and synchronous clear.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             sat
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      q   <= '0;
      sat <= 1'b0;
    end else if (inc) begin
      // Hold at all-ones; the increment that would wrap raises the flag instead.
      if (q == {WIDTH{1'b1}}) begin
        sat <= 1'b1;
      end else begin
        q <= q + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/seq_detector.sv
// Serial bit-pattern detector with runtime-loadable pattern, overlap mode and
// saturating match counter.
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned         PAT_LEN = DefPatLen,
  parameter logic [PAT_LEN-1:0]  PATTERN = PAT_LEN'(DefPattern),
  parameter bit                  OVERLAP = 1'b1,
  parameter int unsigned         CNT_W   = DefCntW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_we,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               tone,
  output logic [CNT_W-1:0]   match_count,
  output logic               cnt_sat
);

  localparam int unsigned      FillW    = fill_width(PAT_LEN);
  localparam logic [FillW-1:0] FillFull = FillW'(PAT_LEN);

  det_state_e         state_q, state_d;
  logic [FillW-1:0]   fill_q, fill_d, fill_next;
  logic [PAT_LEN-1:0] hist_q, hist_d, hist_next;
  logic [PAT_LEN-1:0] pattern_q, pattern_d;
  logic               overlap_q, overlap_d;
  logic               tone_q;
  logic               match;

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    hist_d    = hist_q;
    pattern_d = pattern_q;
    overlap_d = overlap_q;
    match     = 1'b0;
    hist_next = {hist_q[PAT_LEN-2:0], in_bit};
    fill_next = (state_q == StArmed) ? FillFull : fill_q + FillW'(1);

    if (cfg_we) begin
      // New configuration restarts the window; the bit on this cycle is dropped.
      pattern_d = cfg_pattern;
      overlap_d = cfg_overlap;
      fill_d    = '0;
      hist_d    = '0;
      state_d   = StFilling;
    end else if (in_valid) begin
      match  = (fill_next == FillFull) && (hist_next == pattern_q);
      hist_d = hist_next;
      fill_d = fill_next;
      case (state_q)
        StFilling: if (fill_next == FillFull) state_d = StArmed;
        StArmed:   state_d = StArmed;
        default:   state_d = StFilling;
      endcase
      if (match && !overlap_q) begin
        fill_d  = '0;
        state_d = StFilling;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFilling;
      fill_q    <= '0;
      hist_q    <= '0;
      pattern_q <= PATTERN;
      overlap_q <= OVERLAP;
      tone_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      hist_q    <= hist_d;
      pattern_q <= pattern_d;
      overlap_q <= overlap_d;
      tone_q    <= match;
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_match_cnt (
    .clk(clk),
    .rst(rst),
    .inc(match),
    .clr(cnt_clr),
    .q  (match_count),
    .sat(cnt_sat)
  );

  assign tone = tone_q;

endmodule

// File: tb/tb_seq_detector.sv
// Scoreboard bench for seq_detector: a window-of-bits reference model queues the
// expected outputs per cycle and a monitor compares them after each clock edge.
module tb_seq_detector;

  localparam int unsigned PatLen = 6;
  localparam int unsigned CntW   = 8;
  localparam logic [PatLen-1:0] DefPat = 6'b101001;
  localparam bit DefOv = 1'b1;
  localparam int CntMax = (1 << CntW) - 1;

  typedef struct packed {
    logic            tone;
    logic [CntW-1:0] cnt;
    logic            sat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_bit = 1'b0;
  logic              cfg_we = 1'b0;
  logic [PatLen-1:0] cfg_pattern = '0;
  logic              cfg_overlap = 1'b0;
  logic              cnt_clr = 1'b0;
  logic              tone;
  logic [CntW-1:0]   match_count;
  logic              cnt_sat;

  seq_detector #(
    .PAT_LEN(PatLen),
    .PATTERN(DefPat),
    .OVERLAP(DefOv),
    .CNT_W  (CntW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap),
    .cnt_clr    (cnt_clr),
    .tone       (tone),
    .match_count(match_count),
    .cnt_sat    (cnt_sat)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  // Reference model: the valid bits seen since the window last restarted.
  bit                m_win[$];
  logic [PatLen-1:0] m_pat = DefPat;
  bit                m_ov  = DefOv;
  int                m_cnt = 0;

  task automatic check(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs (called just after a falling edge) and queue the
  // outputs expected after the next rising edge.
  task automatic apply(input bit r, input bit v, input bit b, input bit we,
                       input logic [PatLen-1:0] pat, input bit ov, input bit clr);
    bit   match;
    exp_t e;
    rst = r; in_valid = v; in_bit = b; cfg_we = we;
    cfg_pattern = pat; cfg_overlap = ov; cnt_clr = clr;
    match = 1'b0;
    if (r) begin
      m_win.delete();
      m_pat = DefPat;
      m_ov  = DefOv;
      m_cnt = 0;
    end else begin
      if (we) begin
        m_pat = pat;
        m_ov  = ov;
        m_win.delete();
      end else if (v) begin
        m_win.push_back(b);
        if (m_win.size() > PatLen) void'(m_win.pop_front());
        if (m_win.size() == PatLen) begin
          match = 1'b1;
          for (int i = 0; i < PatLen; i++)
            if (m_win[i] != m_pat[PatLen-1-i]) match = 1'b0;
        end
        if (match && !m_ov) m_win.delete();
      end
      if (clr) m_cnt = 0;
      else if (match) m_cnt++;
    end
    e.tone = match;
    e.cnt  = CntW'((m_cnt > CntMax) ? CntMax : m_cnt);
    e.sat  = (m_cnt > CntMax);
    exp_q.push_back(e);
  endtask

  task automatic step(input bit v, input bit b);
    @(negedge clk);
    apply(1'b0, v, b, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i]);
  endtask

  task automatic cfg(input logic [PatLen-1:0] pat, input bit ov, input bit b);
    @(negedge clk);
    apply(1'b0, 1'b1, b, 1'b1, pat, ov, 1'b0);
  endtask

  task automatic clear();
    @(negedge clk);
    apply(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    apply(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    check("async_reset_count", int'(match_count), 0);
    check("async_reset_tone", int'(tone), 0);
  endtask

  // Checks the counter against a hand-derived value, then idles one cycle.
  task automatic check_cnt(input string nm, input int req);
    @(negedge clk);
    check(nm, int'(match_count), req);
    apply(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Monitor: one expected entry per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("tone", int'(tone), int'(e.tone));
        check("match_count", int'(match_count), int'(e.cnt));
        check("cnt_sat", int'(cnt_sat), int'(e.sat));
      end
    end
  end

  initial begin
    bit r, v, b, we, ov, clr;
    logic [PatLen-1:0] pat;

    do_reset();
    do_reset();
    send(32'b101001, 6);
    check_cnt("default_match", 1);

    // Gap of three idle cycles inside the pattern.
    send(32'b101, 3);
    repeat (3) step(1'b0, 1'b1);
    send(32'b001, 3);
    check_cnt("gapped_match", 2);
    clear();
    check_cnt("clear", 0);

    cfg(6'b001001, 1'b1, 1'b1);
    send(32'b001001001, 9);
    check_cnt("overlap_on", 2);
    cfg(6'b001001, 1'b0, 1'b0);
    send(32'b001001001, 9);
    check_cnt("overlap_off", 3);
    cfg(6'b111111, 1'b1, 1'b0);
    send(32'hff, 8);
    check_cnt("ones_overlap", 6);

    // Reset mid-stream discards the partial pattern and restores the default.
    do_reset();
    send(32'b10100, 5);
    do_reset();
    send(32'b1, 1);
    check_cnt("reset_midstream", 0);

    // Config write on the completing bit drops that bit.
    send(32'b10100, 5);
    cfg(DefPat, 1'b1, 1'b1);
    send(32'b1, 1);
    check_cnt("cfg_discard", 0);

    // Saturation: 260 overlapping matches, then clear racing a match.
    cfg(6'b111111, 1'b1, 1'b0);
    for (int i = 0; i < 265; i++) step(1'b1, 1'b1);
    @(negedge clk);
    check("sat_flag", int'(cnt_sat), 1);
    apply(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check_cnt("sat_count", CntMax);
    @(negedge clk);
    apply(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    check_cnt("clr_wins", 0);

    // Random stream with occasional config, clear and reset.
    for (int ph = 0; ph < 2; ph++) begin
      cfg(6'(ph == 0 ? 6'b110110 : 6'b010101), ph[0], 1'b0);
      for (int i = 0; i < 5000; i++) begin
        r   = ($urandom_range(0, 999) == 0);
        we  = ($urandom_range(0, 299) == 0);
        clr = ($urandom_range(0, 499) == 0);
        v   = ($urandom_range(0, 9) < 8);
        b   = 1'($urandom);
        pat = PatLen'($urandom);
        ov  = (ph == 0) ? 1'b0 : 1'b1;
        @(negedge clk);
        apply(r, v, b, we, pat, ov, clr);
      end
    end

    @(negedge clk);
    apply(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_detector.md
# seq_detector

Parametrised serial bit-pattern detector: the clocked, configurable successor to the team's fixed 101001 stream detector. Samples one qualified bit per cycle and compares the most recent PAT_LEN bits against a runtime-loadable pattern. Emits a one-cycle `tone` pulse per match and keeps a saturating match counter. Sits directly on a serial data stream ahead of status/interrupt logic.

## Interface
- PAT_LEN, 6, pattern length in bits (2..32)
- PATTERN, 6'b101001, reset value of the match pattern; MSB is the first bit received
- OVERLAP, 1, reset value of overlap mode (1 = overlapping matches counted, 0 = non-overlapping)
- CNT_W, 8, match counter width (1..32)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous and active-high
- in_valid  in  1  qualifies in_bit this cycle
- in_bit  in  1  serial stream bit
- cfg_we  in  1  load cfg_pattern/cfg_overlap this cycle
- cfg_pattern  in  PAT_LEN  new pattern
- cfg_overlap  in  1  new overlap mode
- cnt_clr  in  1  synchronous clear of match_count and cnt_sat
- tone  out  1  one-cycle match pulse, registered
- match_count  out  CNT_W  number of matches since reset/clear
- cnt_sat  out  1  sticky: counter has saturated

## Operation
- History: PAT_LEN-bit shift register; on accepted bit, hist <= {hist[PAT_LEN-2:0], in_bit}.
- Fill: counter 0..PAT_LEN, saturating at PAT_LEN; +1 per accepted bit.
- Match condition (combinational on the next-state values): fill_next == PAT_LEN and hist_next == pattern.
- States: FILLING (fill < PAT_LEN), ARMED (fill == PAT_LEN). FILLING -> ARMED when fill reaches PAT_LEN. ARMED -> FILLING (fill = 0) on a match only when overlap = 0. Overlap = 1: stays ARMED; the next match can occur one bit later (e.g. pattern 1111 on 11111 -> 2 matches).
- in_valid = 0: no state change, no tone.
- cfg_we = 1: pattern/overlap load; fill <= 0, hist <= 0; the in_bit that cycle is discarded; counter untouched. cfg_we has priority over in_valid.
- Counter: +1 per match; at all-ones it holds and cnt_sat <= 1 (set on the match that would wrap). cnt_clr = 1 clears both; cnt_clr with a simultaneous match -> count 0, cnt_sat 0 (clear wins), tone still pulses.
- Reset values: tone 0, match_count 0, cnt_sat 0, hist 0, fill 0, pattern = PATTERN, overlap = OVERLAP.
- Reset asserted mid-stream: all state to reset values immediately; partial pattern discarded.

## Timing
- Latency: tone high in the cycle after the clk edge that accepts the last pattern bit (one register stage); match_count updated on that same edge.
- tone is high for exactly one cycle per match; back-to-back matches (overlap, consecutive valid bits) give consecutive tone cycles.
- Gaps in in_valid do not break a sequence; only the valid bits count.
- Config takes effect for the bit accepted on the cycle after cfg_we.
- No combinational path from inputs to outputs.

## Structure
- Package seq_det_pkg: default PAT_LEN/CNT_W constants, state enum (FILLING, ARMED), fill-width function $clog2(PAT_LEN+1).
- Sub-module sat_counter (WIDTH param; inc, clr, q, sat), reused for match_count/cnt_sat.
- Top holds history, fill, config registers and match compare.

## Test plan
- Defaults, stream 101001 with in_valid = 1 -> tone pulse 1 cycle after 6th bit, match_count = 1.
- Overlap = 1, pattern 1001 (cfg_we, PAT_LEN = 4), stream 1001001 -> 2 matches, tones after bits 4 and 7; overlap = 0, same stream -> 1 match.
- Stream 101001 with in_valid low for 3 cycles between bits 3 and 4 -> single match, same tone position relative to last valid bit.
- CNT_W = 2, 4 matches -> count 3, cnt_sat = 1 after 4th; cnt_clr together with a 5th match -> count 0, cnt_sat 0, tone high.
- Reset after bits 10100 then bit 1 -> no tone; cfg_we on the 6th-bit cycle -> bit discarded, no match.
- Random 10k-bit stream vs. reference model, both overlap modes -> tone and match_count identical every cycle.
